nvram_backup_ctrl: RTL and testbench



---
 rtl/nvram_backup_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_nvram_backup_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_backup_ctrl.sv
// Moves the 8 KiB CD-i NVRAM between the HPS save image and cditop's NVRAM port B:
// restore on mount, backup on save request or after a quiet period following CPU writes.
module nvram_backup_ctrl #(
    parameter int unsigned SAVE_DELAY = 30_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    input  logic        autosave_en,
    input  logic        save_req,
    input  logic        nvram_cpu_changed,
    input  logic [7:0]  nvram_backup_data,
    output logic [12:0] nvram_backup_restore_adr,
    output logic [7:0]  nvram_restore_data,
    output logic        nvram_restore_write,
    output logic        nvram_allow_cpu_access,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitAckHi,
        StWaitAckLo,
        StNext
    } state_e;

    state_e      state_q, state_d;
    logic        dir_q, dir_d;
    logic [3:0]  sector_q, sector_d;
    logic        sd_rd_q, sd_rd_d;
    logic        sd_wr_q, sd_wr_d;
    logic [31:0] sd_lba_q, sd_lba_d;
    logic        mounted_q, mounted_d;
    logic        ro_q, ro_d;
    logic        mount_pend_q, mount_pend_d;
    logic        save_pend_q, save_pend_d;
    logic        dirty_q, dirty_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;

    logic        mount_clr;
    logic        save_clr;
    logic        dirty_clr;
    logic        can_backup;
    logic        autosave_due;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            dir_q        <= 1'b0;
            sector_q     <= 4'd0;
            sd_rd_q      <= 1'b0;
            sd_wr_q      <= 1'b0;
            sd_lba_q     <= 32'd0;
            mounted_q    <= 1'b0;
            ro_q         <= 1'b0;
            mount_pend_q <= 1'b0;
            save_pend_q  <= 1'b0;
            dirty_q      <= 1'b0;
            idle_cnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            sector_q     <= sector_d;
            sd_rd_q      <= sd_rd_d;
            sd_wr_q      <= sd_wr_d;
            sd_lba_q     <= sd_lba_d;
            mounted_q    <= mounted_d;
            ro_q         <= ro_d;
            mount_pend_q <= mount_pend_d;
            save_pend_q  <= save_pend_d;
            dirty_q      <= dirty_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign can_backup   = mounted_q && !ro_q;
    assign autosave_due = dirty_q && autosave_en && can_backup && (idle_cnt_q >= SAVE_DELAY);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        sector_d   = sector_q;
        sd_rd_d    = sd_rd_q;
        sd_wr_d    = sd_wr_q;
        sd_lba_d   = sd_lba_q;
        mounted_d  = mounted_q;
        ro_d       = ro_q;
        idle_cnt_d = idle_cnt_q;
        mount_clr  = 1'b0;
        save_clr   = 1'b0;
        dirty_clr  = 1'b0;

        if (img_mounted) begin
            mounted_d = (img_size != 64'd0);
            ro_d      = img_readonly;
        end

        if (nvram_cpu_changed) begin
            idle_cnt_d = 32'd0;
        end else if (idle_cnt_q != 32'hFFFF_FFFF) begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end

        case (state_q)
            StIdle: begin
                // Requests that can never be served by the current image are dropped.
                if (!mounted_q) begin
                    mount_clr = 1'b1;
                end
                if (!can_backup) begin
                    save_clr = 1'b1;
                end
                if (mount_pend_q && mounted_q) begin
                    state_d   = StReq;
                    dir_d     = 1'b0;
                    sector_d  = 4'd0;
                    mount_clr = 1'b1;
                end else if ((save_pend_q && can_backup) || autosave_due) begin
                    state_d   = StReq;
                    dir_d     = 1'b1;
                    sector_d  = 4'd0;
                    save_clr  = 1'b1;
                    dirty_clr = 1'b1;
                end
            end
            StReq: begin
                sd_lba_d = {28'd0, sector_q};
                sd_rd_d  = !dir_q;
                sd_wr_d  = dir_q;
                state_d  = StWaitAckHi;
            end
            StWaitAckHi: begin
                if (sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = StWaitAckLo;
                end
            end
            StWaitAckLo: begin
                if (!sd_ack) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (sector_q == 4'hF) begin
                    state_d = StIdle;
                end else begin
                    sector_d = sector_q + 4'd1;
                    state_d  = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A new event in the same cycle as its consumption must not be lost.
        mount_pend_d = img_mounted || (mount_pend_q && !mount_clr);
        save_pend_d  = save_req || (save_pend_q && !save_clr);
        dirty_d      = nvram_cpu_changed || (dirty_q && !dirty_clr);
    end

    assign nvram_backup_restore_adr = {sector_q, sd_buff_addr};
    assign nvram_restore_data       = sd_buff_dout;
    assign nvram_restore_write      = sd_buff_wr && sd_ack && (state_q == StWaitAckLo) && !dir_q;
    assign sd_buff_din              = nvram_backup_data;
    assign nvram_allow_cpu_access   = (state_q == StIdle);
    assign busy                     = (state_q != StIdle);
    assign sd_rd                    = sd_rd_q;
    assign sd_wr                    = sd_wr_q;
    assign sd_lba                   = sd_lba_q;

endmodule

// File: tb/tb_nvram_backup_ctrl.sv
// Bench for nvram_backup_ctrl: HPS sector-buffer model, NVRAM port model and an
// expected-NVRAM/expected-image reference used to check restores, backups and timing.
module tb_nvram_backup_ctrl;

    localparam int unsigned SD = 100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        img_mounted = 1'b0;
    logic        img_readonly = 1'b0;
    logic [63:0] img_size = 64'd0;
    logic        autosave_en = 1'b0;
    logic        save_req = 1'b0;
    logic        nvram_cpu_changed;
    logic [7:0]  nvram_backup_data;
    logic [12:0] nvram_backup_restore_adr;
    logic [7:0]  nvram_restore_data;
    logic        nvram_restore_write;
    logic        nvram_allow_cpu_access;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack = 1'b0;
    logic [8:0]  sd_buff_addr = 9'd0;
    logic [7:0]  sd_buff_dout = 8'd0;
    logic        sd_buff_wr = 1'b0;
    logic [7:0]  sd_buff_din;
    logic        busy;

    logic        cpu_we = 1'b0;
    logic [12:0] cpu_adr = 13'd0;
    logic [7:0]  cpu_dat = 8'd0;

    logic [7:0]  mem    [8192];
    logic [7:0]  img    [8192];
    logic [7:0]  exp_nv [8192];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    assign nvram_cpu_changed = cpu_we;

    nvram_backup_ctrl #(
        .SAVE_DELAY(SD)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .img_mounted             (img_mounted),
        .img_readonly            (img_readonly),
        .img_size                (img_size),
        .autosave_en             (autosave_en),
        .save_req                (save_req),
        .nvram_cpu_changed       (nvram_cpu_changed),
        .nvram_backup_data       (nvram_backup_data),
        .nvram_backup_restore_adr(nvram_backup_restore_adr),
        .nvram_restore_data      (nvram_restore_data),
        .nvram_restore_write     (nvram_restore_write),
        .nvram_allow_cpu_access  (nvram_allow_cpu_access),
        .sd_lba                  (sd_lba),
        .sd_rd                   (sd_rd),
        .sd_wr                   (sd_wr),
        .sd_ack                  (sd_ack),
        .sd_buff_addr            (sd_buff_addr),
        .sd_buff_dout            (sd_buff_dout),
        .sd_buff_wr              (sd_buff_wr),
        .sd_buff_din             (sd_buff_din),
        .busy                    (busy)
    );

    // Dual-port NVRAM: port A is the CPU, port B is the controller (1-clock read latency).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (nvram_restore_write) mem[nvram_backup_restore_adr] <= nvram_restore_data;
        if (cpu_we) mem[cpu_adr] <= cpu_dat;
        nvram_backup_data <= mem[nvram_backup_restore_adr];
    end

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 8192; i++) if (mem[i] !== exp_nv[i]) n++;
        return n;
    endfunction

    function automatic int img_diff();
        int n = 0;
        for (int i = 0; i < 8192; i++) if (img[i] !== exp_nv[i]) n++;
        return n;
    endfunction

    task automatic scramble_img();
        for (int i = 0; i < 8192; i++) img[i] = 8'($urandom_range(255, 0));
    endtask

    task automatic take_img();
        for (int i = 0; i < 8192; i++) exp_nv[i] = img[i];
    endtask

    task automatic cpu_write(output int edge_cyc);
        int a;
        a = $urandom_range(8191, 0);
        cpu_adr = 13'(a);
        cpu_dat = 8'($urandom_range(255, 0));
        cpu_we  = 1'b1;
        exp_nv[a] = cpu_dat;
        @(negedge clk);
        cpu_we   = 1'b0;
        edge_cyc = cyc;
    endtask

    task automatic mount(input bit ro, input logic [63:0] size, output int edge_cyc);
        img_mounted  = 1'b1;
        img_readonly = ro;
        img_size     = size;
        @(negedge clk);
        img_mounted = 1'b0;
        edge_cyc    = cyc;
    endtask

    // HPS side of one 16-sector transfer; optionally remounts mid-way or stops inside a sector.
    task automatic serve_xfer(input bit is_wr, input int mount_sec, input int abort_sec,
                              input int exp_start);
        int drop_cyc;
        int t;
        int dummy;
        drop_cyc = 0;
        for (int s = 0; s < 16; s++) begin
            t = 0;
            while (sd_rd !== 1'b1 && sd_wr !== 1'b1 && t < 4000) begin
                @(negedge clk);
                t++;
            end
            compared++;
            if (sd_rd !== 1'b1 && sd_wr !== 1'b1) begin
                mismatched++;
                $display("FAIL req_timeout: sector %0d no request after %0d clocks, want one", s, t);
                return;
            end
            compared++;
            if (sd_wr !== is_wr || sd_rd !== !is_wr || sd_lba !== 32'(s)) begin
                mismatched++;
                $display("FAIL req_kind: got wr=%b rd=%b lba=%0d, want wr=%b rd=%b lba=%0d",
                         sd_wr, sd_rd, sd_lba, is_wr, !is_wr, s);
            end
            compared++;
            if (nvram_allow_cpu_access !== 1'b0 || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL cpu_block: got allow=%b busy=%b, want allow=0 busy=1",
                         nvram_allow_cpu_access, busy);
            end
            if (s == 0 && exp_start >= 0) begin
                compared++;
                if (cyc != exp_start) begin
                    mismatched++;
                    $display("FAIL start_latency: got clock %0d, want clock %0d", cyc, exp_start);
                end
            end
            if (s > 0) begin
                compared++;
                if (cyc != drop_cyc + 3) begin
                    mismatched++;
                    $display("FAIL ack_to_req: got %0d clocks, want 3", cyc - drop_cyc);
                end
            end
            sd_ack = 1'b1;
            @(negedge clk);
            compared++;
            if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
                mismatched++;
                $display("FAIL req_drop: got rd=%b wr=%b, want 0 0", sd_rd, sd_wr);
            end
            if (s == mount_sec) mount(1'b0, 64'd8192, dummy);
            if (s == abort_sec) begin
                for (int off = 0; off < 8; off++) begin
                    sd_buff_addr = 9'(off);
                    sd_buff_dout = img[s*512+off];
                    sd_buff_wr   = 1'b1;
                    @(negedge clk);
                end
                return;
            end
            for (int off = 0; off < 512; off++) begin
                sd_buff_addr = 9'(off);
                if (is_wr) begin
                    @(negedge clk);
                    @(negedge clk);
                    img[s*512+off] = sd_buff_din;
                end else begin
                    sd_buff_dout = img[s*512+off];
                    sd_buff_wr   = 1'b1;
                    @(negedge clk);
                end
            end
            sd_buff_wr = 1'b0;
            sd_ack     = 1'b0;
            drop_cyc   = cyc;
            @(negedge clk);
        end
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_hold: got busy=%b one clock after last ack, want 1", busy);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || nvram_allow_cpu_access !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_fall: got busy=%b allow=%b, want 0 1", busy, nvram_allow_cpu_access);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({busy, nvram_allow_cpu_access, sd_rd, sd_wr, nvram_restore_write} !== 5'b01000
            || sd_lba !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_vals: got busy/allow/rd/wr/wen=%b lba=%0h, want 01000 lba=0",
                     {busy, nvram_allow_cpu_access, sd_rd, sd_wr, nvram_restore_write}, sd_lba);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unmounted();
        int dummy;
        int seen;
        seen = 0;
        mount(1'b0, 64'd0, dummy);
        save_req = 1'b1;
        @(negedge clk);
        save_req = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0) seen++;
        end
        compared++;
        if (seen != 0) begin
            mismatched++;
            $display("FAIL size0_idle: got %0d busy clocks, want 0", seen);
        end
    endtask

    task automatic test_restore_mount();
        int m;
        for (int i = 0; i < 8192; i++) img[i] = 8'(i & 255);
        mount(1'b0, 64'd8192, m);
        serve_xfer(1'b0, -1, -1, m + 2);
        take_img();
        compared++;
        if (mem_diff() != 0) begin
            mismatched++;
            $display("FAIL restore_data: got %0d bad bytes, want 0", mem_diff());
        end
        compared++;
        if (mem[13'h1234] !== 8'h34) begin
            mismatched++;
            $display("FAIL restore_1234: got %0h, want 34", mem[13'h1234]);
        end
    endtask

    task automatic test_autosave();
        int e;
        int seen;
        scramble_img();
        autosave_en = 1'b1;
        repeat (5) @(negedge clk);
        cpu_write(e);
        repeat (49) @(negedge clk);
        cpu_write(e);
        serve_xfer(1'b1, -1, -1, e + int'(SD) + 2);
        compared++;
        if (img_diff() != 0) begin
            mismatched++;
            $display("FAIL autosave_data: got %0d bad image bytes, want 0", img_diff());
        end
        seen = 0;
        repeat (2 * SD) begin
            @(negedge clk);
            if (busy !== 1'b0) seen++;
        end
        compared++;
        if (seen != 0) begin
            mismatched++;
            $display("FAIL dirty_clear: got %0d busy clocks after autosave, want 0", seen);
        end
        autosave_en = 1'b0;
    endtask

    task automatic test_save_remount();
        int s;
        scramble_img();
        save_req = 1'b1;
        @(negedge clk);
        save_req = 1'b0;
        s = cyc;
        serve_xfer(1'b1, 7, -1, s + 2);
        compared++;
        if (img_diff() != 0) begin
            mismatched++;
            $display("FAIL save_data: got %0d bad image bytes, want 0", img_diff());
        end
        scramble_img();
        serve_xfer(1'b0, -1, -1, cyc + 2);
        take_img();
        compared++;
        if (mem_diff() != 0) begin
            mismatched++;
            $display("FAIL remount_data: got %0d bad bytes, want 0", mem_diff());
        end
    endtask

    task automatic test_readonly();
        int m;
        int e;
        int seen;
        scramble_img();
        mount(1'b1, 64'd8192, m);
        serve_xfer(1'b0, -1, -1, m + 2);
        take_img();
        compared++;
        if (mem_diff() != 0) begin
            mismatched++;
            $display("FAIL ro_restore: got %0d bad bytes, want 0", mem_diff());
        end
        autosave_en = 1'b1;
        cpu_write(e);
        save_req = 1'b1;
        @(negedge clk);
        save_req = 1'b0;
        seen = 0;
        repeat (3 * SD) begin
            @(negedge clk);
            if (sd_wr !== 1'b0 || busy !== 1'b0) seen++;
        end
        compared++;
        if (seen != 0) begin
            mismatched++;
            $display("FAIL ro_no_write: got %0d clocks with wr/busy, want 0", seen);
        end
        autosave_en = 1'b0;
    endtask

    task automatic test_reset_abort();
        int m;
        int bad;
        scramble_img();
        mount(1'b0, 64'd8192, m);
        serve_xfer(1'b0, -1, 3, m + 2);
        reset_n = 1'b0;
        #1;
        compared++;
        if ({busy, nvram_allow_cpu_access, sd_rd, sd_wr, nvram_restore_write} !== 5'b01000
            || sd_lba !== 32'd0) begin
            mismatched++;
            $display("FAIL async_reset: got busy/allow/rd/wr/wen=%b lba=%0h, want 01000 lba=0",
                     {busy, nvram_allow_cpu_access, sd_rd, sd_wr, nvram_restore_write}, sd_lba);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) reset_n = 1'b1;
            if (nvram_restore_write !== 1'b0 || busy !== 1'b0) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL post_reset_write: got %0d clocks with write/busy, want 0", bad);
        end
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        repeat (3) @(negedge clk);
        scramble_img();
        mount(1'b0, 64'd8192, m);
        serve_xfer(1'b0, -1, -1, m + 2);
        take_img();
        compared++;
        if (mem_diff() != 0) begin
            mismatched++;
            $display("FAIL rerestore_data: got %0d bad bytes, want 0", mem_diff());
        end
    endtask

    initial begin
        test_reset();
        test_unmounted();
        test_restore_mount();
        test_autosave();
        test_save_remount();
        test_readonly();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
